// File: rtl/izhikevich_core_param.sv
// Izhikevich neuron update core: one Euler step per accepted neuron, four register
// stages, sign-magnitude saturating arithmetic, valid/ready flow control and a spike counter.
module izhikevich_core_param #(
  parameter int unsigned     WIDTH = 17,
  parameter int unsigned     FRAC  = 8,
  parameter int unsigned     ID_W  = 8,
  parameter logic [WIDTH-1:0] K2    = 17'h0000A,
  parameter logic [WIDTH-1:0] K1    = 17'h00500,
  parameter logic [WIDTH-1:0] K0    = 17'h08C00,
  parameter logic [WIDTH-1:0] VPEAK = 17'h01E00,
  parameter logic [WIDTH-1:0] VMIN  = 17'h13200,
  parameter int unsigned     CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_id,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [WIDTH-1:0] v_prime,
  output logic [WIDTH-1:0] u_prime,
  output logic             fired,
  output logic [CNT_W-1:0] spike_count
);

  localparam int unsigned MW = WIDTH - 1;
  localparam logic [MW-1:0] MAG_MAX = '1;

  typedef logic [WIDTH-1:0] word_t;
  // Two's complement with room for the exact sum of two full-scale magnitudes.
  typedef logic signed [WIDTH:0] wide_t;

  function automatic wide_t to_wide(input word_t x);
    wide_t m;
    m = $signed({2'b00, x[MW-1:0]});
    return x[WIDTH-1] ? -m : m;
  endfunction

  // Saturate to the magnitude range; zero always comes out as +0.
  function automatic word_t from_wide(input wide_t s);
    wide_t lim;
    wide_t n;
    lim = $signed({2'b00, MAG_MAX});
    n   = -s;
    if (s > lim)       return {1'b0, MAG_MAX};
    else if (s < -lim) return {1'b1, MAG_MAX};
    else if (s[WIDTH]) return {1'b1, n[MW-1:0]};
    else               return {1'b0, s[MW-1:0]};
  endfunction

  function automatic word_t sm_add(input word_t x, input word_t y);
    return from_wide(to_wide(x) + to_wide(y));
  endfunction

  function automatic word_t sm_neg(input word_t x);
    return {~x[WIDTH-1] & (|x[MW-1:0]), x[MW-1:0]};
  endfunction

  function automatic word_t sm_sub(input word_t x, input word_t y);
    return sm_add(x, sm_neg(y));
  endfunction

  function automatic word_t sm_mul(input word_t x, input word_t y);
    logic [2*MW-1:0] p;
    logic [2*MW-1:0] q;
    logic [MW-1:0]   mag;
    p   = {{MW{1'b0}}, x[MW-1:0]} * {{MW{1'b0}}, y[MW-1:0]};
    q   = p >> FRAC;
    mag = (|q[2*MW-1:MW]) ? MAG_MAX : q[MW-1:0];
    return {(|mag) & (x[WIDTH-1] ^ y[WIDTH-1]), mag};
  endfunction

  logic en;
  logic s1_valid, s2_valid, s3_valid;
  logic [ID_W-1:0] s1_id, s2_id, s3_id;
  word_t s1_a, s1_c, s1_d, s1_u, s1_v, s1_i, s1_k2v, s1_k1v, s1_bv;
  word_t s2_a, s2_c, s2_d, s2_u, s2_v, s2_i, s2_vv, s2_k1v, s2_bvu;
  word_t s3_c, s3_d, s3_u, s3_v, s3_s, s3_aterm;
  word_t s_chain, vn, un;
  logic  spike, below_floor;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en & ~rst;

  // Membrane increment chain, each step saturating on its own.
  always_comb begin
    s_chain = sm_add(s2_vv, s2_k1v);
    s_chain = sm_add(s_chain, K0);
    s_chain = sm_sub(s_chain, s2_u);
    s_chain = sm_add(s_chain, s2_i);
  end

  // Final state update and spike / floor decision.
  always_comb begin
    vn          = sm_add(s3_v, s3_s);
    un          = sm_add(s3_u, s3_aterm);
    spike       = to_wide(vn) >= to_wide(VPEAK);
    below_floor = to_wide(vn) < to_wide(VMIN);
  end

  // Datapath stage registers; contents are only meaningful under the matching valid.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_id    <= in_id;
      s1_a     <= a;
      s1_c     <= c;
      s1_d     <= d;
      s1_u     <= u;
      s1_v     <= v;
      s1_i     <= i;
      s1_k2v   <= sm_mul(K2, v);
      s1_k1v   <= sm_mul(K1, v);
      s1_bv    <= sm_mul(b, v);
      s2_id    <= s1_id;
      s2_a     <= s1_a;
      s2_c     <= s1_c;
      s2_d     <= s1_d;
      s2_u     <= s1_u;
      s2_v     <= s1_v;
      s2_i     <= s1_i;
      s2_vv    <= sm_mul(s1_k2v, s1_v);
      s2_k1v   <= s1_k1v;
      s2_bvu   <= sm_sub(s1_bv, s1_u);
      s3_id    <= s2_id;
      s3_c     <= s2_c;
      s3_d     <= s2_d;
      s3_u     <= s2_u;
      s3_v     <= s2_v;
      s3_s     <= s_chain;
      s3_aterm <= sm_mul(s2_a, s2_bvu);
    end
  end

  // Stage valids and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      fired     <= 1'b0;
      out_id    <= '0;
      v_prime   <= '0;
      u_prime   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      out_id    <= s3_id;
      fired     <= s3_valid & spike;
      if (spike) begin
        v_prime <= from_wide(to_wide(s3_c));
        u_prime <= sm_add(s3_u, s3_d);
      end else begin
        v_prime <= below_floor ? VMIN : vn;
        u_prime <= un;
      end
    end
  end

  // Saturating count of spikes handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_count <= '0;
    end else if (out_valid && out_ready && fired && (spike_count != '1)) begin
      spike_count <= spike_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_izhikevich_core_param.sv
// Bench for izhikevich_core_param: integer reference model feeding an in-order scoreboard,
// plus directed spike / sub-threshold / floor / stall / reset cases.
module tb_izhikevich_core_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, fired;
  logic [7:0]  in_id, out_id;
  logic [16:0] a, b, c, d, v, u, i, v_prime, u_prime;
  logic [15:0] spike_count;

  izhikevich_core_param dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_id       (in_id),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .v           (v),
    .u           (u),
    .i           (i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .v_prime     (v_prime),
    .u_prime     (u_prime),
    .fired       (fired),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  id;
    logic [16:0] vp;
    logic [16:0] up;
    logic        fired;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  bit   chk_lat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference model in plain integers (units of 1/256).
  function automatic int dec(input logic [16:0] x);
    return x[16] ? -int'(x[15:0]) : int'(x[15:0]);
  endfunction

  function automatic int sat(input int x);
    if (x > 65535) return 65535;
    if (x < -65535) return -65535;
    return x;
  endfunction

  function automatic logic [16:0] enc(input int x);
    int y;
    y = sat(x);
    return (y < 0) ? {1'b1, 16'(-y)} : {1'b0, 16'(y)};
  endfunction

  function automatic int fmul(input int x, input int y);
    longint p;
    p = longint'(x < 0 ? -x : x) * longint'(y < 0 ? -y : y);
    p = p / 256;
    if (p > 65535) p = 65535;
    return ((x < 0) != (y < 0)) ? -int'(p) : int'(p);
  endfunction

  function automatic exp_t model(input logic [16:0] pa, pb, pc, pd, pu, pv, pi);
    exp_t e;
    int   vi, ui, s, vn, un;
    vi = dec(pv);
    ui = dec(pu);
    s  = fmul(fmul(10, vi), vi);
    s  = sat(s + fmul(1280, vi));
    s  = sat(s + 35840);
    s  = sat(s - ui);
    s  = sat(s + dec(pi));
    vn = sat(vi + s);
    un = sat(ui + fmul(dec(pa), sat(fmul(dec(pb), vi) - ui)));
    if (vn >= 30 * 256) begin
      e.vp    = enc(dec(pc));
      e.up    = enc(ui + dec(pd));
      e.fired = 1'b1;
    end else begin
      e.vp    = (vn < -50 * 256) ? enc(-50 * 256) : enc(vn);
      e.up    = enc(un);
      e.fired = 1'b0;
    end
    e.id  = 8'h00;
    e.acc = 0;
    return e;
  endfunction

  // Scoreboard: pop and compare on output handshake, push on input transfer.
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'h0, out_id}, 32'hFFFF_FFFF);
        end else begin
          me = exp_q.pop_front();
          check("sb_id", out_id, me.id);
          check("sb_v_prime", v_prime, me.vp);
          check("sb_u_prime", u_prime, me.up);
          check("sb_fired", fired, me.fired);
          if (chk_lat) check("sb_latency", cyc - me.acc, 4);
          if (me.fired) exp_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        me     = model(a, b, c, d, u, v, i);
        me.id  = in_id;
        me.acc = cyc;
        exp_q.push_back(me);
      end
    end
  end

  function automatic logic [16:0] rnd_v();
    return enc(int'($urandom_range(0, 120 * 256)) - 80 * 256);
  endfunction

  function automatic logic [16:0] rnd_u();
    return enc(int'($urandom_range(0, 40 * 256)) - 20 * 256);
  endfunction

  function automatic logic [16:0] rnd_i();
    return enc(int'($urandom_range(0, 30 * 256)));
  endfunction

  task automatic send_one(input logic [7:0] id, input logic [16:0] vv, uu, ii);
    @(posedge clk);
    #1;
    in_id    = id;
    v        = vv;
    u        = uu;
    i        = ii;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    check(tag, exp_q.size(), 0);
    #1;
  endtask

  int lat;
  int stale;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_id     = 8'h00;
    a         = 17'h00005;
    b         = 17'h00033;
    c         = 17'h14100;
    d         = 17'h00800;
    v         = '0;
    u         = '0;
    i         = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_spike_count", spike_count, 0);
    check("rst_fired", fired, 0);
    check("rst_v_prime", v_prime, 0);
    check("rst_out_id", out_id, 0);

    // Spike
    send_one(8'd3, 17'h00000, 17'h00000, 17'h00000);
    wait_out(lat);
    check("spike_latency", lat, 4);
    check("spike_id", out_id, 3);
    check("spike_fired", fired, 1);
    check("spike_v_prime", v_prime, 17'h14100);
    check("spike_u_prime", u_prime, 17'h00800);
    @(posedge clk);
    #2 check("spike_count_1", spike_count, 1);

    // Sub-threshold
    send_one(8'd4, 17'h11E00, 17'h00000, 17'h00000);
    wait_out(lat);
    check("sub_latency", lat, 4);
    check("sub_fired", fired, 0);
    check("sub_v_prime", v_prime, 17'h104D8);
    check("sub_u_prime", u_prime, 17'h1001D);

    // Floor
    send_one(8'd5, 17'h13200, 17'h06400, 17'h00000);
    wait_out(lat);
    check("floor_fired", fired, 0);
    check("floor_v_prime", v_prime, 17'h13200);
    check("floor_u_prime", u_prime, 17'h061DB);
    @(posedge clk);
    #1;
    drain("drain_directed");

    // Streaming, back-to-back
    chk_lat = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_id    = 8'(k);
      v        = rnd_v();
      u        = rnd_u();
      i        = rnd_i();
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain("drain_stream");
    chk_lat = 1'b0;
    check("stream_spike_count", spike_count, exp_cnt);

    // Back-pressure
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int  t;
          bit  acc;
          in_id    = 8'(16 + k);
          v        = (k % 2 == 0) ? 17'h00000 : rnd_v();
          u        = rnd_u();
          i        = rnd_i();
          in_valid = 1'b1;
          t        = 0;
          acc      = 1'b0;
          while (!acc && t < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
          end
          if (!acc) check("bp_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          if (exp_q.size() > 0) begin
            check("bp_hold_id", out_id, exp_q[0].id);
            check("bp_hold_v_prime", v_prime, exp_q[0].vp);
            check("bp_hold_u_prime", u_prime, exp_q[0].up);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    @(posedge clk);
    #2 check("bp_spike_count", spike_count, exp_cnt);

    // Reset with three entries in flight
    for (int k = 0; k < 3; k++) begin
      in_id    = 8'(40 + k);
      v        = 17'h00000;
      u        = rnd_u();
      i        = rnd_i();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    exp_cnt  = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_spike_count", spike_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_stale", stale, 0);
    chk_lat = 1'b1;
    send_one(8'd50, rnd_v(), rnd_u(), rnd_i());
    drain("drain_post_rst");
    chk_lat = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
